// File: rtl/mod_counter_if.sv
// rtl/mod_counter_if.sv - control and status bundle for the up/down modulus counter
interface mod_counter_if #(
  parameter int WIDTH = 8
) ();
  logic             enable;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] mod_val;
  logic             wrap;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             match;

  modport master (
    output enable, up_dn, load, load_val, mod_val, wrap, cmp_val,
    input  count, tc, match
  );

  modport slave (
    input  enable, up_dn, load, load_val, mod_val, wrap, cmp_val,
    output count, tc, match
  );
endinterface

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - synchronous up/down counter with modulus, load, wrap/saturate, tc and match
module mod_counter #(
  parameter int          WIDTH   = 8,
  parameter int unsigned RST_VAL = 0
) (
  input logic          clk,
  input logic          rst,
  mod_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tc_q;
  logic             tc_d;
  logic [WIDTH-1:0] load_clamped;

  // Loads never place the count above the current terminal value.
  assign load_clamped = (bus.load_val > bus.mod_val) ? bus.mod_val : bus.load_val;

  // Next-state: load beats enable; tc flags a step taken at the direction's terminal value.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = load_clamped;
    end else if (bus.enable) begin
      if (bus.mod_val == '0) begin
        // A zero modulus pins the count at 0 and every step is terminal.
        count_d = '0;
        tc_d    = 1'b1;
      end else if (bus.up_dn) begin
        if (count_q < bus.mod_val) begin
          count_d = count_q + ONE;
        end else begin
          // At or above the modulus (it may have been lowered under us).
          count_d = bus.wrap ? '0 : bus.mod_val;
          tc_d    = 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          count_d = bus.wrap ? bus.mod_val : '0;
          tc_d    = 1'b1;
        end else if ((count_q > bus.mod_val) && !bus.wrap) begin
          // Saturate mode snaps a stranded count back onto the modulus.
          count_d = bus.mod_val;
        end else begin
          count_d = count_q - ONE;
        end
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= RST_COUNT;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.match = (count_q == bus.cmp_val);

endmodule

// File: tb/tb_mod_counter.sv
// tb/tb_mod_counter.sv - directed self-checking bench for mod_counter
module tb_mod_counter;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  mod_counter_if #(.WIDTH(4)) bus ();

  mod_counter #(.WIDTH(4), .RST_VAL(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_to(input logic [3:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst          = 1'b1;
    bus.enable   = 1'b1;
    bus.up_dn    = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = 4'd0;
    bus.mod_val  = 4'd9;
    bus.wrap     = 1'b1;
    bus.cmp_val  = 4'd3;

    // reset with enable held high
    step();
    check("rst_count", bus.count, 3);
    check("rst_tc", bus.tc, 0);
    check("rst_match", bus.match, 1);
    step();
    check("rst_hold_count", bus.count, 3);

    // wrap up 0..9 then 0
    rst = 1'b0;
    bus.enable = 1'b0;
    load_to(4'd0);
    check("wrap_load0", bus.count, 0);
    bus.enable = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      step();
      check($sformatf("wrap_cnt%0d", i), bus.count, i % 10);
      check($sformatf("wrap_tc%0d", i), bus.tc, (i == 10) ? 1 : 0);
      check($sformatf("wrap_match%0d", i), bus.match, ((i % 10) == 3) ? 1 : 0);
    end

    // saturate down from 2
    bus.enable = 1'b0;
    load_to(4'd2);
    check("sat_load2", bus.count, 2);
    bus.wrap = 1'b0;
    bus.up_dn = 1'b0;
    bus.enable = 1'b1;
    begin
      int exp_c [5] = '{1, 0, 0, 0, 0};
      int exp_t [5] = '{0, 0, 1, 1, 1};
      for (int i = 0; i < 5; i++) begin
        step();
        check($sformatf("satdn_cnt%0d", i), bus.count, exp_c[i]);
        check($sformatf("satdn_tc%0d", i), bus.tc, exp_t[i]);
      end
    end

    // wrap down from 0 goes to mod_val
    bus.wrap = 1'b1;
    step();
    check("wrapdn_cnt", bus.count, 9);
    check("wrapdn_tc", bus.tc, 1);

    // load priority and clamp
    bus.mod_val = 4'd5;
    bus.up_dn = 1'b1;
    bus.enable = 1'b1;
    load_to(4'd12);
    check("ldclamp_cnt", bus.count, 5);
    check("ldclamp_tc", bus.tc, 0);
    step();
    check("ldclamp_up_cnt", bus.count, 0);
    check("ldclamp_up_tc", bus.tc, 1);

    // lowered modulus, wrap up
    bus.enable = 1'b0;
    bus.mod_val = 4'd15;
    load_to(4'd12);
    check("lower_load12", bus.count, 12);
    bus.mod_val = 4'd7;
    bus.enable = 1'b1;
    step();
    check("lower_up_cnt", bus.count, 0);
    check("lower_up_tc", bus.tc, 1);

    // lowered modulus, saturate down
    bus.enable = 1'b0;
    bus.mod_val = 4'd15;
    load_to(4'd12);
    bus.mod_val = 4'd7;
    bus.wrap = 1'b0;
    bus.up_dn = 1'b0;
    bus.enable = 1'b1;
    step();
    check("lower_dn_cnt", bus.count, 7);
    check("lower_dn_tc", bus.tc, 0);

    // idle hold clears tc
    bus.enable = 1'b0;
    step();
    check("idle_cnt", bus.count, 7);
    check("idle_tc", bus.tc, 0);

    // match while counting up with mod 15
    bus.mod_val = 4'd15;
    bus.cmp_val = 4'd4;
    bus.wrap = 1'b1;
    bus.up_dn = 1'b1;
    load_to(4'd0);
    bus.enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("match_cnt%0d", i), bus.count, i);
      check($sformatf("match%0d", i), bus.match, (i == 4) ? 1 : 0);
    end
    bus.cmp_val = 4'd6;
    #1;
    check("match_comb", bus.match, 1);

    // mod 0 holds at zero and tc every enabled cycle
    bus.mod_val = 4'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("mod0_cnt%0d", i), bus.count, 0);
      check($sformatf("mod0_tc%0d", i), bus.tc, 1);
    end
    bus.up_dn = 1'b0;
    bus.wrap = 1'b0;
    step();
    check("mod0_dn_cnt", bus.count, 0);
    check("mod0_dn_tc", bus.tc, 1);

    // reset mid-count overrides load and enable
    bus.mod_val = 4'd15;
    bus.up_dn = 1'b1;
    bus.enable = 1'b0;
    load_to(4'd5);
    check("midrst_pre", bus.count, 5);
    rst = 1'b1;
    bus.load = 1'b1;
    bus.load_val = 4'd10;
    bus.enable = 1'b1;
    step();
    check("midrst_cnt", bus.count, 3);
    check("midrst_tc", bus.tc, 0);
    rst = 1'b0;
    bus.load = 1'b0;
    step();
    check("midrst_resume", bus.count, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mod_counter.md
# mod_counter

Synchronous, parametrised up/down counter. It replaces the single-direction ripple counter in the SPI datapath as the shared bit, frame and prescale counter. It adds a programmable modulus, parallel load, wrap or saturate mode, a terminal-count pulse and a compare-match flag. All flops are clocked by the single system clock; there are no derived clocks.

## Interface
Parameters:
- WIDTH, 8: counter width in bits; legal values 1–32.
- RST_VAL, 0: count value after reset; must not exceed 2^WIDTH-1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  step enable; one step per enabled cycle.
- up_dn  in  1  direction: 1 = up, 0 = down.
- load  in  1  parallel load strobe.
- load_val  in  WIDTH  value written on load.
- mod_val  in  WIDTH  terminal value; the count range is 0..mod_val.
- wrap  in  1  boundary mode: 1 = wrap, 0 = saturate.
- cmp_val  in  WIDTH  compare value.
- count  out  WIDTH  current count (registered).
- tc  out  1  terminal-count pulse (registered).
- match  out  1  high when count == cmp_val.

## Operation
- Priority per edge is rst > load > enable > hold.
- rst: count <= RST_VAL; tc <= 0.
- load: count <= min(load_val, mod_val). tc <= 0. Any enable in the same cycle is ignored.
- enable, up step:
  - If count < mod_val, count <= count+1.
  - If count >= mod_val: in wrap mode count <= 0; in saturate mode count <= mod_val.
- enable, down step:
  - If count > 0, count <= count-1, except when count > mod_val. In that case, in saturate mode only, count <= mod_val.
  - If count == 0: in wrap mode count <= mod_val; in saturate mode count <= 0.
- Terminal event: an enabled step taken while count is at the terminal value for the current direction. For up, that is count >= mod_val; for down, count == 0. On a terminal event tc <= 1; on every other edge tc <= 0.
- In saturate mode, tc re-asserts on every enabled cycle spent held at the terminal value.
- mod_val == 0: count is held at 0. tc asserts after every enabled cycle, in both modes and both directions.
- mod_val may change at any time and takes effect on the next edge. A count left above a lowered mod_val is handled by the up and down rules above; it never keeps counting upward past mod_val.
- match = (count == cmp_val): a combinational compare of registered count against cmp_val, with no extra state.
- enable low with load low: count and cmp relationship hold; tc <= 0.

## Timing
- count and tc are registered and update one clk edge after the inputs are sampled. There are no combinational paths from enable, up_dn, load, mod_val or wrap to any output.
- tc is high for exactly the one cycle following the terminal event edge. It is concurrent with the count holding the wrapped or saturated value.
- match follows count in the same cycle. It also responds combinationally to cmp_val.
- Reset values:
  - count = RST_VAL.
  - tc = 0.
  - match = (RST_VAL == cmp_val).
- Reset asserted mid-count overrides load and enable on that edge. Counting resumes from RST_VAL on the first edge after rst deasserts.
- Changing direction between consecutive enabled cycles is legal. Each step uses the up_dn value sampled on its own edge.
- Max throughput: one step per clock. No idle cycles are required after load or rst.

## Test plan
- Reset: WIDTH=4, RST_VAL=3, cmp_val=3 → after a rst edge count=3, tc=0, match=1. With enable=1 held during rst, count stays 3.
- Wrap up: mod_val=9, wrap=1, up_dn=1, enable=1 from count=0 → count runs 0..9 then 0. tc is high only in the cycle count returns to 0, once per 10 cycles.
- Saturate down: count=2, mod_val=9, wrap=0, up_dn=0, 5 enabled cycles → count 1,0,0,0,0. tc is high in each of the last three cycles.
- Load priority and clamp: mod_val=5, load=1 with load_val=12 and enable=1 in the same cycle → count=5, tc=0. Next enabled up step with wrap=1 → count=0, tc=1.
- Lowered modulus: count=12, mod_val changed to 7. One up step with wrap=1 → count=0, tc=1. Repeat with wrap=0 and a down step → count=7, tc=0.
- Match and mod 0: cmp_val=4 while counting up with mod_val=15 → match is high exactly while count=4. Then set mod_val=0 with enable=1 for 3 cycles → count=0 and tc is high in all three cycles.
